// File: rtl/apuf_eval_ctrl.sv
// rtl/apuf_eval_ctrl.sv - arbiter-PUF evaluation sequencer with majority vote
//
// Drives one arbiter-PUF request: holds the challenge on the delay-line
// selects, fires NUM_EVAL launch pulses, samples the synchronised arbiter
// output once per pulse and reports the ones count and the majority bit.
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   start        request an evaluation (accepted only while idle)
//   challenge    challenge word, captured on the accepting edge
//   busy         high from the accepting edge until the return to idle
//   done         one-cycle pulse, response/ones_cnt valid
//   response     majority result, held until the next done
//   ones_cnt     number of samples equal to 1, held until the next done
//   puf_chal     registered challenge to the delay-line selects
//   puf_launch   launch edge into both delay paths
//   puf_resp     arbiter flop output, asynchronous to clk

module apuf_eval_ctrl #(
    parameter int CHAL_W     = 64,
    parameter int SETTLE_CYC = 4,
    parameter int NUM_EVAL   = 5,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CHAL_W-1:0] challenge,
    output logic              busy,
    output logic              done,
    output logic              response,
    output logic [CNT_W-1:0]  ones_cnt,
    output logic [CHAL_W-1:0] puf_chal,
    output logic              puf_launch,
    input  logic              puf_resp
);

    localparam int                PH_W      = $clog2(SETTLE_CYC);
    localparam logic [PH_W-1:0]   PH_LOAD   = PH_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  EVAL_LAST = CNT_W'(NUM_EVAL);
    localparam logic [CNT_W-1:0]  HALF      = CNT_W'(NUM_EVAL / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_FIRE,
        S_SAMPLE,
        S_RELAX,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [PH_W-1:0]  ph;
    logic [CNT_W-1:0] eval_cnt;
    logic [CNT_W-1:0] ones;
    logic             rs1;
    logic             rs2;
    logic             accept;
    logic             busy_next;
    logic             done_next;
    logic             launch_next;

    assign accept = (state == S_IDLE) && start;

    // Arbiter output is asynchronous; only rs2 is ever looked at.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1 <= 1'b0;
            rs2 <= 1'b0;
        end else begin
            rs1 <= puf_resp;
            rs2 <= rs1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_SETUP;
            S_SETUP:  if (ph == '0) state_next = S_FIRE;
            S_FIRE:   if (ph == '0) state_next = S_SAMPLE;
            S_SAMPLE: state_next = S_RELAX;
            S_RELAX:  if (ph == '0) state_next = (eval_cnt == EVAL_LAST) ? S_DONE : S_FIRE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Every phase change reloads the phase counter, so each timed phase
    // lasts exactly SETTLE_CYC cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph       <= '0;
            eval_cnt <= '0;
            ones     <= '0;
        end else begin
            if (state_next != state) begin
                ph <= PH_LOAD;
            end else if (ph != '0) begin
                ph <= ph - PH_W'(1);
            end
            if (accept) begin
                eval_cnt <= '0;
                ones     <= '0;
            end else if (state == S_SAMPLE) begin
                eval_cnt <= eval_cnt + CNT_W'(1);
                ones     <= ones + CNT_W'(rs2);
            end
        end
    end

    // Outputs are decoded from the next state and registered, so they
    // line up with the state they describe without combinational paths.
    always_comb begin
        busy_next   = (state_next != S_IDLE);
        done_next   = (state_next == S_DONE);
        launch_next = (state_next == S_FIRE) || (state_next == S_SAMPLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            puf_launch <= 1'b0;
            puf_chal   <= '0;
            ones_cnt   <= '0;
            response   <= 1'b0;
        end else begin
            busy       <= busy_next;
            done       <= done_next;
            puf_launch <= launch_next;
            if (accept) begin
                puf_chal <= challenge;
            end
            if (state_next == S_DONE) begin
                ones_cnt <= ones;
                response <= (ones > HALF);
            end
        end
    end

endmodule

// File: tb/tb_apuf_eval_ctrl.sv
// tb/tb_apuf_eval_ctrl.sv - self-checking bench for apuf_eval_ctrl

module tb_apuf_eval_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_s   [2];
    logic [63:0] chal_in   [2];
    logic        resp_in   [2];
    logic        busy_s    [2];
    logic        done_s    [2];
    logic        response_s[2];
    logic [7:0]  ones_s    [2];
    logic [63:0] pchal_s   [2];
    logic        launch_s  [2];

    always #5 clk = ~clk;

    apuf_eval_ctrl u_a (
        .clk        (clk),
        .rst        (rst),
        .start      (start_s[0]),
        .challenge  (chal_in[0]),
        .busy       (busy_s[0]),
        .done       (done_s[0]),
        .response   (response_s[0]),
        .ones_cnt   (ones_s[0]),
        .puf_chal   (pchal_s[0]),
        .puf_launch (launch_s[0]),
        .puf_resp   (resp_in[0])
    );

    apuf_eval_ctrl #(
        .SETTLE_CYC (3),
        .NUM_EVAL   (1)
    ) u_b (
        .clk        (clk),
        .rst        (rst),
        .start      (start_s[1]),
        .challenge  (chal_in[1]),
        .busy       (busy_s[1]),
        .done       (done_s[1]),
        .response   (response_s[1]),
        .ones_cnt   (ones_s[1]),
        .puf_chal   (pchal_s[1]),
        .puf_launch (launch_s[1]),
        .puf_resp   (resp_in[1])
    );

    int checks = 0;
    int errors = 0;

    function automatic int sp(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    function automatic int nv(input int k);
        return (k == 0) ? 5 : 1;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Behavioural model: a request is a time window starting at its
    // accepting edge e0; every output is a function of the offset from e0.
    int          cyc = 0;
    bit          act      [2];
    int          e0       [2];
    logic [63:0] mchal    [2];
    int          acc      [2];
    int          mones    [2];
    bit          mresp    [2];
    bit          hist     [2][8];

    initial begin
        int t, p, l;
        forever begin
            @(posedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                hist[k][cyc % 8] = resp_in[k];
                p = 2 * sp(k) + 1;
                l = sp(k) + nv(k) * p;
                if (rst) begin
                    act[k]   = 1'b0;
                    mchal[k] = '0;
                    acc[k]   = 0;
                    mones[k] = 0;
                    mresp[k] = 1'b0;
                end else if (act[k]) begin
                    t = cyc - e0[k];
                    // sample i is taken at edge e0+(i+1)*p from the level
                    // the arbiter showed two edges earlier
                    if ((t % p) == 0 && (t / p) >= 1 && (t / p) <= nv(k))
                        acc[k] += int'(hist[k][(cyc - 2) % 8]);
                    if (t == l) begin
                        mones[k] = acc[k];
                        mresp[k] = (acc[k] > nv(k) / 2);
                    end
                    if (t == l + 1) act[k] = 1'b0;
                end else if (start_s[k]) begin
                    act[k]   = 1'b1;
                    e0[k]    = cyc;
                    mchal[k] = chal_in[k];
                    acc[k]   = 0;
                end
            end
        end
    end

    int rise_cnt[2];
    int done_cnt[2];
    bit prev_l  [2];

    initial begin
        int t, s, n, p, l, o;
        bit eb, ed, el;
        repeat (2) @(negedge clk);
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                s = sp(k);
                n = nv(k);
                p = 2 * s + 1;
                l = s + n * p;
                t = cyc - e0[k];
                o = t - s;
                eb = act[k];
                ed = act[k] && (t == l);
                el = act[k] && (o >= 0) && (o < n * p) && ((o % p) <= s);
                chk($sformatf("busy%0d@%0d", k, cyc), 64'(busy_s[k]), 64'(eb));
                chk($sformatf("done%0d@%0d", k, cyc), 64'(done_s[k]), 64'(ed));
                chk($sformatf("launch%0d@%0d", k, cyc), 64'(launch_s[k]), 64'(el));
                chk($sformatf("puf_chal%0d@%0d", k, cyc), pchal_s[k], mchal[k]);
                chk($sformatf("ones_cnt%0d@%0d", k, cyc), 64'(ones_s[k]), 64'(mones[k]));
                chk($sformatf("response%0d@%0d", k, cyc), 64'(response_s[k]), 64'(mresp[k]));
                if (launch_s[k] && !prev_l[k]) rise_cnt[k]++;
                prev_l[k] = launch_s[k];
                if (done_s[k]) done_cnt[k]++;
            end
        end
    end

    // mode 0: per-sample pattern, 1: level 1 then drop just before the
    // sample, 2: rise just before the sample, 3: random, 4: random plus
    // start hammered with fresh challenges while busy
    task automatic run(input int k, input logic [63:0] ch, input int mode,
                       input logic [4:0] pat, output int lat);
        int p, r, idx, e;
        p   = 2 * sp(k) + 1;
        lat = -1;
        @(negedge clk);
        start_s[k] = 1'b1;
        chal_in[k] = ch;
        @(negedge clk);
        e = cyc;
        chk("accept_busy", 64'(busy_s[k]), 64'(1));
        chk("accept_chal", pchal_s[k], ch);
        if (mode != 4) start_s[k] = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done_s[k]) begin
                lat = cyc - e;
                break;
            end
            r   = (cyc - e) % p + 1;
            idx = (cyc - e) / p;
            case (mode)
                0:       resp_in[k] = (idx < 5) ? pat[idx] : 1'b0;
                1:       resp_in[k] = (r >= p - 6) && (r <= p - 2);
                2:       resp_in[k] = (r >= p - 1);
                default: resp_in[k] = 1'($urandom % 2);
            endcase
            if (mode == 4) begin
                start_s[k] = 1'b1;
                chal_in[k] = {$urandom, $urandom};
            end
            @(negedge clk);
        end
        if (mode == 4) begin
            start_s[k] = 1'b1;
            chal_in[k] = {$urandom, $urandom};
        end
        if (lat < 0) chk("run_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog cycles=%0d limit=90000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [63:0] ch;
        for (int k = 0; k < 2; k++) begin
            start_s[k] = 1'b0;
            chal_in[k] = '0;
            resp_in[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // defaults, arbiter stuck at 1
        rise_cnt[0] = 0;
        run(0, 64'hA5A5_0000_FFFF_1234, 0, 5'b11111, lat);
        chk("t2_latency", 64'(lat), 64'(49));
        chk("t2_ones", 64'(ones_s[0]), 64'(5));
        chk("t2_resp", 64'(response_s[0]), 64'(1));
        chk("t2_rises", 64'(rise_cnt[0]), 64'(5));
        chk("t2_chal", pchal_s[0], 64'hA5A5_0000_FFFF_1234);

        // per-sample patterns 1,0,1,0,1 and 0,1,0,0,1
        run(0, 64'h0123_4567_89AB_CDEF, 0, 5'b10101, lat);
        chk("t3a_ones", 64'(ones_s[0]), 64'(3));
        chk("t3a_resp", 64'(response_s[0]), 64'(1));
        run(0, 64'hFEDC_BA98_7654_3210, 0, 5'b10010, lat);
        chk("t3b_ones", 64'(ones_s[0]), 64'(2));
        chk("t3b_resp", 64'(response_s[0]), 64'(0));

        // late toggles are not seen by the sample
        run(0, 64'h1111_2222_3333_4444, 1, 5'b00000, lat);
        chk("t6a_ones", 64'(ones_s[0]), 64'(5));
        chk("t6a_resp", 64'(response_s[0]), 64'(1));
        run(0, 64'h5555_6666_7777_8888, 2, 5'b00000, lat);
        chk("t6b_ones", 64'(ones_s[0]), 64'(0));
        chk("t6b_resp", 64'(response_s[0]), 64'(0));

        // start hammered while busy, then back-to-back request
        done_cnt[0] = 0;
        run(0, 64'hDEAD_BEEF_CAFE_F00D, 4, 5'b00000, lat);
        chk("t4_chal_held", pchal_s[0], 64'hDEAD_BEEF_CAFE_F00D);
        chk("t4_latency", 64'(lat), 64'(49));
        run(0, 64'h0F0F_0F0F_0F0F_0F0F, 0, 5'b11111, lat);
        @(negedge clk);
        chk("t4_done_count", 64'(done_cnt[0]), 64'(2));

        // reset in the middle of a launch pulse
        start_s[0] = 1'b1;
        chal_in[0] = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        start_s[0] = 1'b0;
        begin
            int w;
            w = 0;
            while (!launch_s[0] && w < 50) begin
                @(negedge clk);
                w++;
            end
            chk("t1_reached_fire", 64'(launch_s[0]), 64'(1));
        end
        #2 rst = 1'b1;
        #1;
        chk("t1_launch_async", 64'(launch_s[0]), 64'(0));
        chk("t1_busy", 64'(busy_s[0]), 64'(0));
        chk("t1_done", 64'(done_s[0]), 64'(0));
        chk("t1_ones", 64'(ones_s[0]), 64'(0));
        chk("t1_chal", pchal_s[0], 64'(0));
        @(negedge clk);
        rst = 1'b0;
        rise_cnt[0] = 0;
        repeat (10) @(negedge clk);
        chk("t1_no_launch", 64'(rise_cnt[0]), 64'(0));
        chk("t1_idle_busy", 64'(busy_s[0]), 64'(0));

        // short configuration
        resp_in[1] = 1'b0;
        run(1, 64'hAAAA_5555_AAAA_5555, 0, 5'b00000, lat);
        chk("t5_latency", 64'(lat), 64'(10));
        chk("t5_ones", 64'(ones_s[1]), 64'(0));
        chk("t5_resp", 64'(response_s[1]), 64'(0));
        run(1, 64'h0000_0000_0000_0001, 0, 5'b00001, lat);
        chk("t5b_ones", 64'(ones_s[1]), 64'(1));
        chk("t5b_resp", 64'(response_s[1]), 64'(1));

        // randomised requests on both instances, checked by the model
        for (int i = 0; i < 24; i++) begin
            int k, m;
            k  = int'($urandom % 2);
            m  = (($urandom % 3) == 0) ? 4 : ((($urandom % 2) == 0) ? 3 : 0);
            ch = {$urandom, $urandom};
            run(k, ch, m, 5'($urandom), lat);
            start_s[k] = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
